// File: rtl/fsm_prog_pkg.sv
// Shared definitions for the programmable Moore FSM: state-width helper,
// reset-default constants and the state-update selector type.
package fsm_prog_pkg;

  localparam int STATE_RESET = 0;
  localparam int OUT_RESET   = 0;

  // Which source feeds the state register on the coming edge.
  typedef enum logic [1:0] {
    UPD_HOLD    = 2'd0,
    UPD_STEP    = 2'd1,
    UPD_RESTART = 2'd2
  } upd_e;

  // State register width; never narrower than one bit.
  function automatic int calc_sw(input int n);
    if (n <= 2) return 1;
    return $clog2(n);
  endfunction

endpackage

// File: rtl/fsm_prog_moore_if.sv
// Control, table-write and status signals of the programmable Moore FSM.
// The master drives stepping and configuration; the FSM is the slave.
interface fsm_prog_moore_if #(
  parameter int p_nstates = 4,
  parameter int p_nin     = 1,
  parameter int p_nout    = 2
);
  import fsm_prog_pkg::*;

  localparam int SW = calc_sw(p_nstates);

  logic              en;
  logic              restart;
  logic [p_nin-1:0]  in_;
  logic              tw_en;
  logic [SW-1:0]     tw_state;
  logic [p_nin-1:0]  tw_in;
  logic [SW-1:0]     tw_next;
  logic              ow_en;
  logic [SW-1:0]     ow_state;
  logic [p_nout-1:0] ow_data;
  logic [SW-1:0]     state;
  logic [p_nout-1:0] out;
  logic              changed;
  logic              err;

  modport master (
    output en, restart, in_,
    output tw_en, tw_state, tw_in, tw_next,
    output ow_en, ow_state, ow_data,
    input  state, out, changed, err
  );

  modport slave (
    input  en, restart, in_,
    input  tw_en, tw_state, tw_in, tw_next,
    input  ow_en, ow_state, ow_data,
    output state, out, changed, err
  );

endinterface

// File: rtl/fsm_prog_table.sv
// Register array with one write port, one asynchronous read port and an
// asynchronous reset that loads each entry with its initial value.
// With INIT_ROW_IDX set, entry k resets to (k >> INIT_ROW_SHIFT), which makes
// a transition table of self-loops; otherwise every entry resets to OUT_RESET.
module fsm_prog_table
  import fsm_prog_pkg::*;
#(
  parameter int DEPTH          = 4,
  parameter int WIDTH          = 2,
  parameter int AW             = 2,
  parameter int INIT_ROW_SHIFT = 0,
  parameter bit INIT_ROW_IDX   = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we_i,
  input  logic [AW-1:0]    wa_i,
  input  logic [WIDTH-1:0] wd_i,
  input  logic [AW-1:0]    ra_i,
  output logic [WIDTH-1:0] rd_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  function automatic logic [WIDTH-1:0] init_val(input int idx);
    if (INIT_ROW_IDX) return WIDTH'(idx >> INIT_ROW_SHIFT);
    return WIDTH'(OUT_RESET);
  endfunction

  // Entry storage: reset to initial contents, then single-port writes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < DEPTH; k++) begin
        mem_q[k] <= init_val(k);
      end
    end else if (we_i) begin
      mem_q[wa_i] <= wd_i;
    end
  end

  assign rd_o = mem_q[ra_i];

endmodule

// File: rtl/fsm_prog_moore.sv
// Runtime-programmable Moore FSM. A state register walks a writable
// transition table T[state][in_]; the Moore output is O[state] from a
// writable output table. Writes naming a state outside 0..p_nstates-1 are
// dropped and flagged on err for one cycle, so state stays in range.
module fsm_prog_moore
  import fsm_prog_pkg::*;
#(
  parameter int p_nstates = 4,
  parameter int p_nin     = 1,
  parameter int p_nout    = 2
) (
  input  logic          clk,
  input  logic          reset,
  fsm_prog_moore_if.slave bus
);

  localparam int SW     = calc_sw(p_nstates);
  localparam int TDEPTH = p_nstates * (1 << p_nin);
  localparam logic [SW:0] NS_LIM = (SW+1)'(p_nstates);

  logic [SW-1:0]     state_q, state_d;
  logic              changed_q, changed_d;
  logic              err_q, err_d;
  logic [SW-1:0]     t_rd;
  logic [p_nout-1:0] o_rd;
  logic              tw_ok, ow_ok;
  logic              tw_we, ow_we;
  upd_e              upd;

  // One extra bit keeps the compare meaningful when p_nstates is a power of two.
  function automatic logic state_ok(input logic [SW-1:0] s);
    return ({1'b0, s} < NS_LIM);
  endfunction

  // Write validation: only in-range rows and next-states reach the tables.
  always_comb begin
    tw_ok = state_ok(bus.tw_state) && state_ok(bus.tw_next);
    ow_ok = state_ok(bus.ow_state);
    tw_we = bus.tw_en && tw_ok;
    ow_we = bus.ow_en && ow_ok;
    err_d = (bus.tw_en && !tw_ok) || (bus.ow_en && !ow_ok);
  end

  // Transition table, addressed {source state, input}; resets to self-loops.
  fsm_prog_table #(
    .DEPTH          (TDEPTH),
    .WIDTH          (SW),
    .AW             (SW + p_nin),
    .INIT_ROW_SHIFT (p_nin),
    .INIT_ROW_IDX   (1'b1)
  ) u_ttab (
    .clk   (clk),
    .reset (reset),
    .we_i  (tw_we),
    .wa_i  ({bus.tw_state, bus.tw_in}),
    .wd_i  (bus.tw_next),
    .ra_i  ({state_q, bus.in_}),
    .rd_o  (t_rd)
  );

  // Output table, one entry per state; resets to all zero.
  fsm_prog_table #(
    .DEPTH          (p_nstates),
    .WIDTH          (p_nout),
    .AW             (SW),
    .INIT_ROW_SHIFT (0),
    .INIT_ROW_IDX   (1'b0)
  ) u_otab (
    .clk   (clk),
    .reset (reset),
    .we_i  (ow_we),
    .wa_i  (bus.ow_state),
    .wd_i  (bus.ow_data),
    .ra_i  (state_q),
    .rd_o  (o_rd)
  );

  // Next-state selection: restart beats en; the table read sees the old entry.
  always_comb begin
    upd       = UPD_HOLD;
    state_d   = state_q;
    changed_d = 1'b0;
    if (bus.restart) begin
      upd = UPD_RESTART;
    end else if (bus.en) begin
      upd = UPD_STEP;
    end
    case (upd)
      UPD_RESTART: state_d = SW'(STATE_RESET);
      UPD_STEP:    state_d = t_rd;
      default:     state_d = state_q;
    endcase
    changed_d = (state_d != state_q);
  end

  // State register plus one-cycle changed/err status flops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= SW'(STATE_RESET);
      changed_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      changed_q <= changed_d;
      err_q     <= err_d;
    end
  end

  assign bus.state   = state_q;
  assign bus.out     = o_rd;
  assign bus.changed = changed_q;
  assign bus.err     = err_q;

endmodule

// File: tb/tb_fsm_prog_moore.sv
// Bench for fsm_prog_moore: a 4-state instance (A) and a 3-state instance (B),
// an array-based reference model checked every cycle, and directed scenarios
// with hand-computed literal expectations.
module tb_fsm_prog_moore;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  fsm_prog_moore_if #(.p_nstates(4), .p_nin(1), .p_nout(2)) ifa ();
  fsm_prog_moore_if #(.p_nstates(3), .p_nin(1), .p_nout(2)) ifb ();

  fsm_prog_moore #(.p_nstates(4), .p_nin(1), .p_nout(2)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (ifa)
  );

  fsm_prog_moore #(.p_nstates(3), .p_nin(1), .p_nout(2)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (ifb)
  );

  int n_chk = 0;
  int n_err = 0;
  bit chk_on = 1'b0;

  // Reference model: k=0 is instance A, k=1 is instance B.
  int m_state [2];
  int m_T     [2][4][2];
  int m_O     [2][4];
  int m_chg   [2];
  int m_err   [2];
  int NS      [2] = '{4, 3};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset(input int k);
    for (int s = 0; s < 4; s++) begin
      for (int i = 0; i < 2; i++) m_T[k][s][i] = s;
      m_O[k][s] = 0;
    end
    m_state[k] = 0;
    m_chg[k]   = 0;
    m_err[k]   = 0;
  endtask

  task automatic model_clock(input int k, input int en, input int restart, input int in_,
                             input int tw_en, input int tw_state, input int tw_in, input int tw_next,
                             input int ow_en, input int ow_state, input int ow_data);
    int old_s, new_s, bad;
    old_s = m_state[k];
    if (restart != 0)  new_s = 0;
    else if (en != 0)  new_s = m_T[k][old_s][in_];
    else               new_s = old_s;
    bad = 0;
    if (tw_en != 0) begin
      if (tw_state < NS[k] && tw_next < NS[k]) m_T[k][tw_state][tw_in] = tw_next;
      else bad = 1;
    end
    if (ow_en != 0) begin
      if (ow_state < NS[k]) m_O[k][ow_state] = ow_data;
      else bad = 1;
    end
    m_state[k] = new_s;
    m_chg[k]   = (new_s != old_s) ? 1 : 0;
    m_err[k]   = bad;
  endtask

  // Model advances on the same edges as the DUTs, reset asynchronously.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      model_reset(0);
      model_reset(1);
    end else begin
      model_clock(0, int'(ifa.en), int'(ifa.restart), int'(ifa.in_), int'(ifa.tw_en),
                  int'(ifa.tw_state), int'(ifa.tw_in), int'(ifa.tw_next),
                  int'(ifa.ow_en), int'(ifa.ow_state), int'(ifa.ow_data));
      model_clock(1, int'(ifb.en), int'(ifb.restart), int'(ifb.in_), int'(ifb.tw_en),
                  int'(ifb.tw_state), int'(ifb.tw_in), int'(ifb.tw_next),
                  int'(ifb.ow_en), int'(ifb.ow_state), int'(ifb.ow_data));
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("A.state",   32'(ifa.state),   32'(m_state[0]));
      chk("A.out",     32'(ifa.out),     32'(m_O[0][m_state[0]]));
      chk("A.changed", 32'(ifa.changed), 32'(m_chg[0]));
      chk("A.err",     32'(ifa.err),     32'(m_err[0]));
      chk("B.state",   32'(ifb.state),   32'(m_state[1]));
      chk("B.out",     32'(ifb.out),     32'(m_O[1][m_state[1]]));
      chk("B.changed", 32'(ifb.changed), 32'(m_chg[1]));
      chk("B.err",     32'(ifb.err),     32'(m_err[1]));
    end
  end

  task automatic idle();
    ifa.en = 1'b0; ifa.restart = 1'b0; ifa.in_ = 1'b0;
    ifa.tw_en = 1'b0; ifa.tw_state = 2'd0; ifa.tw_in = 1'b0; ifa.tw_next = 2'd0;
    ifa.ow_en = 1'b0; ifa.ow_state = 2'd0; ifa.ow_data = 2'd0;
    ifb.en = 1'b0; ifb.restart = 1'b0; ifb.in_ = 1'b0;
    ifb.tw_en = 1'b0; ifb.tw_state = 2'd0; ifb.tw_in = 1'b0; ifb.tw_next = 2'd0;
    ifb.ow_en = 1'b0; ifb.ow_state = 2'd0; ifb.ow_data = 2'd0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic twa(input int s, input int i, input int n);
    ifa.tw_en = 1'b1; ifa.tw_state = 2'(s); ifa.tw_in = 1'(i); ifa.tw_next = 2'(n);
  endtask

  task automatic twb(input int s, input int i, input int n);
    ifb.tw_en = 1'b1; ifb.tw_state = 2'(s); ifb.tw_in = 1'(i); ifb.tw_next = 2'(n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : stim
    int ring [5];
    int walk [4];
    ring = '{1, 2, 3, 0, 1};
    walk = '{1, 2, 0, 1};
    reset = 1'b1;
    idle();
    chk_on = 1'b1;
    tick();
    tick();
    reset = 1'b0;

    // Reset defaults: self-loops everywhere, out stays 0.
    ifa.in_ = 1'b1;
    for (int c = 0; c < 4; c++) begin
      ifa.en = ~ifa.en;
      tick();
      chk("rst.state",   32'(ifa.state),   32'd0);
      chk("rst.out",     32'(ifa.out),     32'd0);
      chk("rst.changed", 32'(ifa.changed), 32'd0);
    end
    idle();

    // Program a 4-state ring on in_=1, hold on in_=0, O[s]=s.
    for (int s = 0; s < 4; s++) begin
      twa(s, 1, (s + 1) % 4);
      ifa.ow_en = 1'b1; ifa.ow_state = 2'(s); ifa.ow_data = 2'(s);
      tick();
    end
    idle();
    for (int s = 0; s < 4; s++) begin
      twa(s, 0, s);
      tick();
    end
    idle();

    ifa.en = 1'b1; ifa.in_ = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("ring.state",   32'(ifa.state),   32'(ring[c]));
      chk("ring.out",     32'(ifa.out),     32'(ring[c]));
      chk("ring.changed", 32'(ifa.changed), 32'd1);
    end
    ifa.in_ = 1'b0;
    tick();
    chk("hold.state",   32'(ifa.state),   32'd1);
    chk("hold.changed", 32'(ifa.changed), 32'd0);

    // Same-cycle write and step: the step uses the old entry T[1][1]=2.
    ifa.in_ = 1'b1;
    twa(1, 1, 3);
    tick();
    chk("wstep.old", 32'(ifa.state), 32'd2);
    ifa.tw_en = 1'b0;
    tick(); tick(); tick();
    chk("wstep.back", 32'(ifa.state), 32'd1);
    tick();
    chk("wstep.new", 32'(ifa.state), 32'd3);

    // Walk to state 2, restoring T[1][1]=2 on the way.
    twa(1, 1, 2);
    tick();
    ifa.tw_en = 1'b0;
    tick(); tick();
    chk("pre.restart", 32'(ifa.state), 32'd2);

    // Restart beats en; a simultaneous table write still commits.
    ifa.restart = 1'b1;
    twa(0, 1, 2);
    tick();
    chk("restart.state",   32'(ifa.state),   32'd0);
    chk("restart.changed", 32'(ifa.changed), 32'd1);
    ifa.restart = 1'b0; ifa.tw_en = 1'b0;
    tick();
    chk("restart.wr", 32'(ifa.state), 32'd2);

    // Step to state 3 while writing O[3]=3, then reset between edges.
    ifa.ow_en = 1'b1; ifa.ow_state = 2'd3; ifa.ow_data = 2'd3;
    tick();
    chk("async.pre.state", 32'(ifa.state), 32'd3);
    chk("async.pre.out",   32'(ifa.out),   32'd3);
    idle();
    #1 reset = 1'b1;
    #1;
    chk("async.state", 32'(ifa.state), 32'd0);
    chk("async.out",   32'(ifa.out),   32'd0);
    #1 reset = 1'b0;

    // First edge after reset behaves normally.
    ifa.en = 1'b1; ifa.in_ = 1'b1;
    twa(0, 1, 1);
    tick();
    chk("post.self", 32'(ifa.state), 32'd0);
    ifa.tw_en = 1'b0;
    tick();
    chk("post.step", 32'(ifa.state), 32'd1);
    idle();

    // Instance B: 3-state ring, then illegal writes.
    for (int s = 0; s < 3; s++) begin
      twb(s, 1, (s + 1) % 3);
      tick();
    end
    idle();

    twb(3, 1, 0);
    tick();
    chk("ill.row.err", 32'(ifb.err), 32'd1);
    idle();
    tick();
    chk("ill.row.clr", 32'(ifb.err), 32'd0);

    twb(0, 1, 3);
    tick();
    chk("ill.next.err", 32'(ifb.err), 32'd1);
    idle();
    tick();
    chk("ill.next.clr", 32'(ifb.err), 32'd0);

    ifb.ow_en = 1'b1; ifb.ow_state = 2'd3; ifb.ow_data = 2'd3;
    tick();
    chk("ill.ow.err", 32'(ifb.err), 32'd1);
    idle();
    tick();
    chk("ill.ow.clr", 32'(ifb.err), 32'd0);

    ifb.en = 1'b1; ifb.in_ = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("walk3.state", 32'(ifb.state), 32'(walk[c]));
      chk("walk3.out",   32'(ifb.out),   32'd0);
      chk("walk3.err",   32'(ifb.err),   32'd0);
    end
    idle();

    // Valid output write alongside a rejected transition write.
    ifb.ow_en = 1'b1; ifb.ow_state = 2'd1; ifb.ow_data = 2'd2;
    twb(3, 0, 1);
    tick();
    chk("mix.err", 32'(ifb.err), 32'd1);
    chk("mix.out", 32'(ifb.out), 32'd2);
    idle();
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/fsm_prog_moore.md
# fsm_prog_moore

Runtime-programmable, parametrised Moore finite-state machine: a state register plus a writable next-state table and a writable output table. It is the sequential successor to the fixed 4-state/1-input/2-output combinational transition-table blocks. Control logic can retarget its sequencing behaviour through a configuration write port without re-synthesis. It sits between a configuration bus (table writes) and datapath control (per-cycle `in_`, Moore `out`).

## Interface
- `p_nstates`, default 4: number of states; ≥2, need not be a power of two.
- `p_nin`, default 1: input width; the table holds 2^p_nin entries per state.
- `p_nout`, default 2: Moore output width.
- Derived `SW = $clog2(p_nstates)`: state width.

Ports:
- `clk`  in  1  clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `en`  in  1  when high, the state register advances this cycle.
- `restart`  in  1  synchronous return to state 0; wins over `en`.
- `in_`  in  p_nin  FSM input, sampled when `en` is high.
- `tw_en`  in  1  transition-table write strobe.
- `tw_state`  in  SW  transition-table row (source state).
- `tw_in`  in  p_nin  transition-table column (input value).
- `tw_next`  in  SW  next-state value to store.
- `ow_en`  in  1  output-table write strobe.
- `ow_state`  in  SW  output-table row.
- `ow_data`  in  p_nout  output value to store.
- `state`  out  SW  current state, registered.
- `out`  out  p_nout  output-table entry for the current `state` (Moore).
- `changed`  out  1  registered; high for one cycle after the state value changes.
- `err`  out  1  registered; high for one cycle after a rejected write.

## Operation
- Reset (asynchronous, active-high):
  - `state`=0, `changed`=0, `err`=0.
  - Every transition entry [s][i] is set to s (self-loop).
  - Every output entry is set to 0, so `out`=0.
- State update, each rising edge:
  - If `restart`: `state`←0.
  - Else if `en`: `state`←T[state][in_].
  - Else: `state` holds.
- `changed` is set iff the new state ≠ the old state. Restarting from state 0 does not set `changed`.
- `out` is combinational from the registered `state` and the output table only; it never depends on `in_`.
- Table writes take effect at the clock edge:
  - `tw_en`: T[tw_state][tw_in]←tw_next.
  - `ow_en`: O[ow_state]←ow_data.
- Write validation, for non-power-of-two `p_nstates`:
  - A write with `tw_state`, `tw_next` or `ow_state` ≥ `p_nstates` is dropped and raises `err` on the next cycle.
  - Table contents are unchanged by a dropped write.
  - `state` can therefore never hold a value ≥ `p_nstates`.
- A transition write and an output write in the same cycle are independent; both commit if valid.

## Timing
- Next-state latency: 1 cycle from the `en` edge to the new `state`. `out` follows `state` in the same cycle, with no further register stage.
- Write-then-use: a table write and a step in the same cycle use the old entry. The new entry is visible from the following cycle.
- Writing O[current state] changes `out` in the cycle after the write edge.
- `restart` together with `en` and `tw_en`: the state goes to 0, and the write still commits.
- Reset asserted mid-operation clears the state and both tables immediately, without waiting for `clk`. After reset deasserts, the first edge behaves normally.

## Structure
- Package `fsm_prog_pkg`: holds the `SW` computation function and the reset-default constants (`STATE_RESET`=0, `OUT_RESET`=0).
- Sub-module `fsm_prog_table`: a parametrised register array with a single write port and asynchronous reset-to-initial-value. It is instantiated twice: for the transition table (p_nstates·2^p_nin × SW) and for the output table (p_nstates × p_nout).
- Top level: write validation, state register, and `changed`/`err` flops.

## Test plan
- Reset defaults:
  - Stimulus: assert reset, then toggle `en` with `in_`=1 for 4 cycles.
  - Required: `state`=0, `out`=0 and `changed`=0 throughout (self-loops).
- Program a 4-state ring with `p_nin`=1:
  - Program T[s][1]=s+1 mod 4 and T[s][0]=s, plus O[s]=s.
  - Stepping `en`=1, `in_`=1 for 5 cycles gives `state`/`out` = 1,2,3,0,1 and `changed`=1 each cycle.
  - `in_`=0 holds the state and gives `changed`=0.
- Same-cycle write and step:
  - Stimulus: in state 1, write T[1][1]=3 while stepping with `in_`=1.
  - Required: next `state`=2 (old entry). Returning to state 1 and stepping again gives 3.
- Illegal write with `p_nstates`=3:
  - Stimulus: `tw_state`=3 (or `tw_next`=3).
  - Required: `err`=1 for exactly one cycle, and a following walk shows the table unchanged.
- `restart` priority: in state 2 with `en`=1 and `restart`=1, the next `state`=0 and `changed`=1.
- Asynchronous reset mid-walk: assert `reset` between clock edges while in state 3 with O[3]=2'b11. `state`=0 and `out`=0 before the next edge.
